// File: rtl/ysyx_22050612_wb_pkg.sv
// Shared constants and types for the NPC register-file write-back arbiter.
package ysyx_22050612_wb_pkg;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSU = 1'b1;

  localparam int WB_FIFO_DEPTH = 2;
  localparam int WB_FIFO_PTR_W = $clog2(WB_FIFO_DEPTH);

  localparam int WB_ADDR_WIDTH = 5;
  localparam int WB_DATA_WIDTH = 64;

  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] rd;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/ysyx_22050612_wb_fifo.sv
// Two-entry write-back buffer; exposes per-slot valid and rd so the top can build the busy mask.
module ysyx_22050612_wb_fifo
  import ysyx_22050612_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      push,
  input  logic [ADDR_WIDTH-1:0]                     push_rd,
  input  logic [DATA_WIDTH-1:0]                     push_data,
  input  logic                                      pop,
  output logic                                      full,
  output logic                                      empty,
  output logic [ADDR_WIDTH-1:0]                     head_rd,
  output logic [DATA_WIDTH-1:0]                     head_data,
  output logic [WB_FIFO_DEPTH-1:0]                  ent_valid,
  output logic [WB_FIFO_DEPTH-1:0][ADDR_WIDTH-1:0]  ent_rd
);

  logic [ADDR_WIDTH-1:0]    rd_mem   [WB_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    data_mem [WB_FIFO_DEPTH];
  logic [WB_FIFO_DEPTH-1:0] vld;
  logic [WB_FIFO_PTR_W-1:0] wptr;
  logic [WB_FIFO_PTR_W-1:0] rptr;
  logic                     do_push;
  logic                     do_pop;

  // Occupancy is held as one valid bit per slot, which doubles as the busy tap.
  assign full    = &vld;
  assign empty   = ~|vld;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld  <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) begin
        vld[wptr] <= 1'b1;
        wptr      <= wptr + WB_FIFO_PTR_W'(1);
      end
      if (do_pop) begin
        vld[rptr] <= 1'b0;
        rptr      <= rptr + WB_FIFO_PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      rd_mem[wptr]   <= push_rd;
      data_mem[wptr] <= push_data;
    end
  end

  assign head_rd   = rd_mem[rptr];
  assign head_data = data_mem[rptr];
  assign ent_valid = vld;

  always_comb begin
    ent_rd = '0;
    for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
      ent_rd[i] = rd_mem[i];
    end
  end

endmodule

// File: rtl/ysyx_22050612_wb_arbiter.sv
// Write-back arbiter: buffers ALU and LSU results, round-robins them onto the single
// registered regfile write port and publishes a per-register pending-write mask.
module ysyx_22050612_wb_arbiter
  import ysyx_22050612_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_WIDTH-1:0]    alu_rd,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [ADDR_WIDTH-1:0]    lsu_rd,
  input  logic [DATA_WIDTH-1:0]    lsu_data,
  output logic                     wen,
  output logic [ADDR_WIDTH-1:0]    waddr,
  output logic [DATA_WIDTH-1:0]    wdata,
  output logic [2**ADDR_WIDTH-1:0] busy
);

  logic [1:0]                                   push;
  logic [1:0]                                   pop;
  logic [1:0]                                   full;
  logic [1:0]                                   empty;
  logic [ADDR_WIDTH-1:0]                        head_rd   [2];
  logic [DATA_WIDTH-1:0]                        head_data [2];
  logic [1:0][WB_FIFO_DEPTH-1:0]                ent_valid;
  logic [1:0][WB_FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] ent_rd;

  logic                  rr;
  logic                  gnt_valid;
  logic                  gnt_src;
  logic [ADDR_WIDTH-1:0] gnt_rd;
  logic [DATA_WIDTH-1:0] gnt_data;

  // valid/ready: a result moves into its FIFO at a posedge where valid && ready; the producer
  // holds rd/data stable while valid && !ready; ready depends only on rst and FIFO state.
  assign alu_ready      = !rst && !full[SRC_ALU];
  assign lsu_ready      = !rst && !full[SRC_LSU];
  assign push[SRC_ALU]  = alu_valid && alu_ready;
  assign push[SRC_LSU]  = lsu_valid && lsu_ready;

  ysyx_22050612_wb_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push[SRC_ALU]),
    .push_rd   (alu_rd),
    .push_data (alu_data),
    .pop       (pop[SRC_ALU]),
    .full      (full[SRC_ALU]),
    .empty     (empty[SRC_ALU]),
    .head_rd   (head_rd[SRC_ALU]),
    .head_data (head_data[SRC_ALU]),
    .ent_valid (ent_valid[SRC_ALU]),
    .ent_rd    (ent_rd[SRC_ALU])
  );

  ysyx_22050612_wb_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lsu_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push[SRC_LSU]),
    .push_rd   (lsu_rd),
    .push_data (lsu_data),
    .pop       (pop[SRC_LSU]),
    .full      (full[SRC_LSU]),
    .empty     (empty[SRC_LSU]),
    .head_rd   (head_rd[SRC_LSU]),
    .head_data (head_data[SRC_LSU]),
    .ent_valid (ent_valid[SRC_LSU]),
    .ent_rd    (ent_rd[SRC_LSU])
  );

  always_comb begin
    gnt_valid = 1'b0;
    gnt_src   = rr;
    case ({!empty[SRC_LSU], !empty[SRC_ALU]})
      2'b01: begin
        gnt_valid = 1'b1;
        gnt_src   = SRC_ALU;
      end
      2'b10: begin
        gnt_valid = 1'b1;
        gnt_src   = SRC_LSU;
      end
      2'b11: begin
        gnt_valid = 1'b1;
        gnt_src   = rr;
      end
      default: begin
        gnt_valid = 1'b0;
        gnt_src   = rr;
      end
    endcase
  end

  assign gnt_rd   = head_rd[gnt_src];
  assign gnt_data = head_data[gnt_src];

  always_comb begin
    pop = '0;
    if (gnt_valid) begin
      pop[gnt_src] = 1'b1;
    end
  end

  // The pointer only moves when it actually broke a tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr <= SRC_ALU;
    end else if (!empty[SRC_ALU] && !empty[SRC_LSU]) begin
      rr <= ~gnt_src;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen   <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      wen <= gnt_valid && (gnt_rd != '0);
      if (gnt_valid) begin
        waddr <= gnt_rd;
        wdata <= gnt_data;
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int s = 0; s < 2; s++) begin
      for (int e = 0; e < WB_FIFO_DEPTH; e++) begin
        if (ent_valid[s][e]) begin
          busy[ent_rd[s][e]] = 1'b1;
        end
      end
    end
    if (wen) begin
      busy[waddr] = 1'b1;
    end
    busy[0] = 1'b0;
  end

endmodule

// File: tb/tb_ysyx_22050612_wb_arbiter.sv
// Bench for the write-back arbiter: queue-level reference model checked every cycle,
// plus directed scenarios with hand-computed write sequences.
module tb_ysyx_22050612_wb_arbiter;
  import ysyx_22050612_wb_pkg::*;

  localparam int AW = 5;
  localparam int DW = 64;
  localparam int NR = 32;

  logic          clk;
  logic          rst;
  logic          alu_valid;
  logic          alu_ready;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          lsu_valid;
  logic          lsu_ready;
  logic [AW-1:0] lsu_rd;
  logic [DW-1:0] lsu_data;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [NR-1:0] busy;

  ysyx_22050612_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  wb_entry_t     mq_alu[$];
  wb_entry_t     mq_lsu[$];
  logic          m_wen   = 1'b0;
  logic [AW-1:0] m_waddr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic          m_rr    = 1'b0;

  task automatic model_step();
    bit        a_rdy;
    bit        l_rdy;
    int        src;
    wb_entry_t e;
    a_rdy = mq_alu.size() < WB_FIFO_DEPTH;
    l_rdy = mq_lsu.size() < WB_FIFO_DEPTH;
    src = -1;
    if (mq_alu.size() > 0 && mq_lsu.size() > 0) begin
      src  = m_rr ? 1 : 0;
      m_rr = ~m_rr;
    end else if (mq_alu.size() > 0) src = 0;
    else if (mq_lsu.size() > 0) src = 1;
    if (src == 0) e = mq_alu.pop_front();
    if (src == 1) e = mq_lsu.pop_front();
    if (src >= 0) begin
      m_wen   = (e.rd != 0);
      m_waddr = e.rd;
      m_wdata = e.data;
    end else begin
      m_wen = 1'b0;
    end
    if (alu_valid && a_rdy) begin
      e.rd = alu_rd; e.data = alu_data; mq_alu.push_back(e);
    end
    if (lsu_valid && l_rdy) begin
      e.rd = lsu_rd; e.data = lsu_data; mq_lsu.push_back(e);
    end
  endtask

  function automatic logic [NR-1:0] m_busy();
    logic [NR-1:0] b;
    b = '0;
    foreach (mq_alu[i]) b[mq_alu[i].rd] = 1'b1;
    foreach (mq_lsu[i]) b[mq_lsu[i].rd] = 1'b1;
    if (m_wen) b[m_waddr] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mq_alu.delete();
      mq_lsu.delete();
      m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_rr = 1'b0;
    end else begin
      model_step();
    end
  end

  // compare DUT against model every cycle
  initial forever begin
    @(negedge clk);
    chk("wen", wen, m_wen);
    chk("waddr", waddr, m_waddr);
    chk("wdata", wdata, m_wdata);
    chk("alu_ready", alu_ready, !rst && mq_alu.size() < WB_FIFO_DEPTH);
    chk("lsu_ready", lsu_ready, !rst && mq_lsu.size() < WB_FIFO_DEPTH);
    chk("busy", busy, m_busy());
  end

  // ---------------- drivers ----------------
  wb_entry_t alu_stim[$];
  wb_entry_t lsu_stim[$];
  logic      alu_took = 1'b0;
  logic      lsu_took = 1'b0;

  always @(posedge clk) begin
    alu_took <= alu_valid && alu_ready;
    lsu_took <= lsu_valid && lsu_ready;
  end

  initial forever begin
    wb_entry_t e;
    @(negedge clk);
    #1;
    if (alu_valid && alu_took) alu_valid = 1'b0;
    if (!alu_valid && alu_stim.size() > 0) begin
      e = alu_stim.pop_front(); alu_rd = e.rd; alu_data = e.data; alu_valid = 1'b1;
    end
    if (lsu_valid && lsu_took) lsu_valid = 1'b0;
    if (!lsu_valid && lsu_stim.size() > 0) begin
      e = lsu_stim.pop_front(); lsu_rd = e.rd; lsu_data = e.data; lsu_valid = 1'b1;
    end
  end

  task automatic push_alu(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    wb_entry_t e;
    e.rd = rd; e.data = d;
    alu_stim.push_back(e);
  endtask

  task automatic push_lsu(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    wb_entry_t e;
    e.rd = rd; e.data = d;
    lsu_stim.push_back(e);
  endtask

  // ---------------- scoreboard ----------------
  logic [AW-1:0] exp_q[$];
  logic [DW-1:0] exp_data_q[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  int            wr_cyc_q[$];
  int            alu_lo;
  int            lsu_lo;
  int            busy_cnt;
  int            watch_reg;
  int            last_alu_hs;
  bit            busy_any;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (wen) begin
        wr_addr_q.push_back(waddr);
        wr_data_q.push_back(wdata);
        wr_cyc_q.push_back(cyc);
      end
      if (!alu_ready) alu_lo++;
      if (!lsu_ready) lsu_lo++;
      if (busy[watch_reg]) busy_cnt++;
      if (busy != '0) busy_any = 1'b1;
      if (alu_took) last_alu_hs = cyc;
    end
  end

  task automatic clear_obs();
    exp_q.delete(); exp_data_q.delete();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    alu_lo = 0; lsu_lo = 0; busy_cnt = 0; busy_any = 1'b0; last_alu_hs = -100;
  endtask

  task automatic expect_wr(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    exp_q.push_back(rd);
    exp_data_q.push_back(d);
  endtask

  task automatic check_log(input string name);
    chk({name, "_count"}, wr_addr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_addr_q.size(); i++) begin
      chk({name, "_addr"}, wr_addr_q[i], exp_q[i]);
      chk({name, "_data"}, wr_data_q[i], exp_data_q[i]);
    end
  endtask

  function automatic int wr_span();
    if (wr_cyc_q.size() == 0) return -1;
    return wr_cyc_q[wr_cyc_q.size()-1] - wr_cyc_q[0];
  endfunction

  task automatic sync();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (alu_stim.size() == 0 && lsu_stim.size() == 0 && !alu_valid && !lsu_valid &&
          mq_alu.size() == 0 && mq_lsu.size() == 0 && !m_wen) done = 1'b1;
    end
    #2;
    chk({name, "_drain"}, done, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    watch_reg = 0;
    clear_obs();
    repeat (2) @(negedge clk);
    #2;
    chk("rst_wen", wen, 1'b0);
    chk("rst_waddr", waddr, '0);
    chk("rst_wdata", wdata, '0);
    chk("rst_busy", busy, '0);
    chk("rst_alu_ready", alu_ready, 1'b0);
    chk("rst_lsu_ready", lsu_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_alu_ready", alu_ready, 1'b1);
    chk("post_rst_lsu_ready", lsu_ready, 1'b1);

    // single ALU write, one-edge latency, busy for two cycles
    sync();
    clear_obs();
    watch_reg = 5;
    push_alu(5'd5, 64'h1234);
    expect_wr(5'd5, 64'h1234);
    wait_idle("t1", 50);
    check_log("t1");
    chk("t1_latency", (wr_cyc_q.size() > 0) ? wr_cyc_q[0] - last_alu_hs : -1, 1);
    chk("t1_busy5_cycles", busy_cnt, 2);

    // contention: strict alternation, backpressure, nothing lost
    clear_obs();
    for (int i = 1; i <= 4; i++) begin
      push_alu(AW'(i), 64'hA000 + 64'(i));
      push_lsu(AW'(8 + i), 64'hB000 + 64'(8 + i));
      expect_wr(AW'(i), 64'hA000 + 64'(i));
      expect_wr(AW'(8 + i), 64'hB000 + 64'(8 + i));
    end
    wait_idle("t2", 100);
    check_log("t2");
    chk("t2_alu_stall_cycles", alu_lo, 2);
    chk("t2_lsu_stall_cycles", lsu_lo, 3);
    chk("t2_span", wr_span(), 7);

    // rd=0 is consumed silently
    clear_obs();
    push_lsu(5'd0, 64'hFFFF);
    wait_idle("t3", 50);
    check_log("t3");
    chk("t3_busy_any", busy_any, 1'b0);
    chk("t3_waddr", waddr, 5'd0);
    chk("t3_wdata", wdata, 64'hFFFF);

    // reset in the middle of a burst
    clear_obs();
    for (int i = 0; i < 3; i++) begin
      push_alu(AW'(13 + i), 64'hC000 + 64'(i));
      push_lsu(AW'(17 + i), 64'hD000 + 64'(i));
    end
    repeat (3) @(negedge clk);
    #2;
    chk("t4_pre_wen", wen, 1'b1);
    chk("t4_pre_busy", busy != '0, 1'b1);
    rst = 1'b1;
    #1;
    chk("t4_rst_wen", wen, 1'b0);
    chk("t4_rst_busy", busy, '0);
    chk("t4_rst_alu_ready", alu_ready, 1'b0);
    chk("t4_rst_lsu_ready", lsu_ready, 1'b0);
    alu_stim.delete(); lsu_stim.delete();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    clear_obs();
    repeat (10) @(negedge clk);
    #2;
    chk("t4_stale_writes", wr_addr_q.size(), 0);
    chk("t4_busy_any", busy_any, 1'b0);

    // ALU streaming alone at full rate
    clear_obs();
    for (int i = 0; i < 8; i++) begin
      push_alu((i % 2 == 1) ? 5'd6 : 5'd3, 64'h500 + 64'(i));
      expect_wr((i % 2 == 1) ? 5'd6 : 5'd3, 64'h500 + 64'(i));
    end
    wait_idle("t5", 60);
    check_log("t5");
    chk("t5_alu_stall_cycles", alu_lo, 0);
    chk("t5_span", wr_span(), 7);

    // same rd from both units back to back
    clear_obs();
    watch_reg = 7;
    push_alu(5'd7, 64'hA7);
    sync();
    push_lsu(5'd7, 64'hB7);
    expect_wr(5'd7, 64'hA7);
    expect_wr(5'd7, 64'hB7);
    wait_idle("t6", 50);
    check_log("t6");
    chk("t6_busy7_cycles", busy_cnt, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
